muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the pipelined MIPS core.
- Supersedes the fixed 32-bit multiplier/HiLo pair. Adds:
  - signed and unsigned MULT/DIV;
  - configurable bits-per-cycle for multiply;
  - busy/done handshake so the hazard logic can stall;
  - flush abort and MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_RADIX_BITS, 1, multiplier bits retired per iteration; must divide WIDTH (allowed 1, 2, 4).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 ignored.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  input  WIDTH  rt operand (divisor / multiplier).
- flush  input  1  abort in-flight operation.
- busy  output  1  unit occupied; pipeline stalls any HI/LO-dependent instruction.
- done  output  1  one-cycle pulse when HI/LO updated by MULT/DIV.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset (rst=0, async): state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Applies mid-operation; the partial result is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start & op∈{0,1}: latch |a|, |b| (signed ops) or raw (unsigned), record result signs, clear accumulator → MUL.
  - start & op∈{2,3} & b≠0: → DIV.
  - start & op∈{2,3} & b=0: stay IDLE; next cycle done=1, div_by_zero=1; hi/lo unchanged.
  - start & op=4: hi←a at that edge. op=5: lo←a. No busy, no done.
  - op 6/7: no effect.
- MUL: shift-add, MUL_RADIX_BITS multiplier bits per edge; N=WIDTH/MUL_RADIX_BITS edges; then → FIX.
- DIV: restoring division, one quotient bit per edge; N=WIDTH edges; then → FIX.
- FIX: one edge.
  - MULT: negate the 2·WIDTH product if signs differed.
  - DIV: quotient negated if sa^sb; remainder takes the dividend's sign.
  - Writes {hi,lo} (MUL) or hi=remainder, lo=quotient (DIV). Sets done=1 for the following cycle → IDLE.
- Timing: start sampled at edge E0 → busy=1 from E0 through E(N+1). hi/lo update and done=1 after E(N+1). busy=0 in the same cycle done=1.
- Back-to-back: a new start is accepted in the cycle done=1.
- start while busy=1: ignored, no queuing. Upstream holds the instruction via stall.
- Signed overflow DIV MIN/−1: lo=MIN, hi=0. No exception.
- Width rule: the 2·WIDTH accumulator wraps modulo 2^(2·WIDTH); divisor compare is WIDTH+1 bits.
- flush=1:
  - In MUL/DIV/FIX: → IDLE next edge; hi/lo unchanged; no done.
  - In IDLE: overrides start (no op, including MTHI/MTLO).
  - flush takes priority over completion in FIX.
- Outputs hi/lo are registered; no combinational path from a/b to any output.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT..OP_MTLO), FSM state enum, counter width clog2(WIDTH+1).
- One sub-module, muldiv_sign_fix: combinational abs/negate helper, WIDTH- and 2·WIDTH-parameterised. Used in load and FIX.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF (WIDTH=32, RADIX=1) → done exactly 33 cycles after start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT a=0xFFFFFFFD(−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same with MUL_RADIX_BITS=4 → done after 9 cycles.
- DIV a=0xFFFFFFF9(−7) b=2 → lo=0xFFFFFFFD(−3), hi=0xFFFFFFFF(−1). DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7 b=0 with hi=0x11, lo=0x22 preloaded by MTHI/MTLO → next cycle done=1, div_by_zero=1; hi=0x11, lo=0x22; busy never high.
- Start MULT, assert flush at iteration 10 → busy=0 next cycle, no done, hi/lo unchanged. A start while busy is ignored. A new start in the done cycle completes correctly.
- Drop rst low at iteration 5 of DIV → immediately busy=0, hi=lo=0. After release, MULTU 3×4 → lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_pkg                                                      |
// | Purpose  : Shared definitions for the iterative multiply/divide unit:      |
// |            HI/LO opcode encodings, FSM state encodings and the iteration   |
// |            counter width helper.                                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  // Opcodes presented on the op port by the EX stage
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Counter must hold the largest iteration count, which is WIDTH itself
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_sign_fix                                                 |
// | Purpose  : Combinational conditional two's-complement negate. Used both to |
// |            take magnitudes of operands at load time and to restore the     |
// |            result signs at the end of an operation.                        |
// | Ports    : val [W-1:0] in  - value to process                              |
// |            neg         in  - 1 = negate, 0 = pass through                  |
// |            res [W-1:0] out - processed value                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_unit                                                     |
// | Purpose  : Iterative signed/unsigned multiply and divide with HI/LO        |
// |            registers. Multiply retires MUL_RADIX_BITS multiplier bits per  |
// |            cycle (shift-add); divide is restoring, one quotient bit per    |
// |            cycle. A final FIX cycle restores signs and writes HI/LO.       |
// | Ports    : clk         in  - rising-edge clock                             |
// |            rst         in  - asynchronous active-low reset                 |
// |            start       in  - request, sampled only while not busy          |
// |            op[2:0]     in  - MULT/MULTU/DIV/DIVU/MTHI/MTLO                 |
// |            a, b        in  - rs / rt operands                              |
// |            flush       in  - abort in-flight operation / suppress start    |
// |            busy        out - unit occupied                                 |
// |            done        out - one-cycle pulse when HI/LO written by mul/div |
// |            div_by_zero out - one-cycle pulse with done for divide by zero  |
// |            hi, lo      out - architectural HI/LO registers                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int MUL_RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int R     = MUL_RADIX_BITS;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_mul_iters = CNT_W'(WIDTH / MUL_RADIX_BITS);
  localparam logic [CNT_W-1:0] c_div_iters = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;      // multiplicand (MUL) or divisor (DIV) magnitude
  logic               r_neg_res;  // negate product / quotient in FIX
  logic               r_neg_rem;  // negate remainder in FIX (dividend sign)
  logic               r_is_div;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  // ---------------- operand load ----------------
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val(a), .neg(w_signed & a[WIDTH-1]), .res(w_abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val(b), .neg(w_signed & b[WIDTH-1]), .res(w_abs_b));

  // ---------------- multiply step ----------------
  // Add multiplicand * low digit into the upper half, then shift the whole
  // accumulator right by R. The W+R-bit sum cannot overflow.
  logic [R-1:0]       w_digit;
  logic [WIDTH+R-1:0] w_partial, w_upper;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_digit    = r_acc[R-1:0];
  assign w_partial  = (WIDTH+R)'(r_opd) * (WIDTH+R)'(w_digit);
  assign w_upper    = (WIDTH+R)'(r_acc[2*WIDTH-1:WIDTH]) + w_partial;
  assign w_mul_next = {w_upper, r_acc[WIDTH-1:R]};

  // ---------------- divide step ----------------
  // Shifted remainder needs WIDTH+1 bits because the old remainder can be
  // as large as divisor-1 before doubling.
  logic [WIDTH:0]     w_rem_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_rem_sub, w_rem_new;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge   = w_rem_sh >= {1'b0, r_opd};
  // Result is < divisor when taken, so the low WIDTH bits are exact
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opd;
  assign w_rem_new  = w_div_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_div_next = {w_rem_new, r_acc[WIDTH-2:0], w_div_ge};

  // ---------------- sign restoration ----------------
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val(r_acc), .neg(r_neg_res), .res(w_prod_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.val(r_acc[WIDTH-1:0]), .neg(r_neg_res), .res(w_quo_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.val(r_acc[2*WIDTH-1:WIDTH]), .neg(r_neg_rem), .res(w_rem_fix));

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_is_div  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_opd     <= w_abs_a;
                r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
                r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_rem <= 1'b0;
                r_is_div  <= 1'b0;
                r_cnt     <= c_mul_iters;
                r_state   <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                  // HI/LO left untouched; just report completion
                  r_done <= 1'b1;
                  r_dbz  <= 1'b1;
                end else begin
                  r_opd     <= w_abs_b;
                  r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
                  r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg_rem <= w_signed & a[WIDTH-1];
                  r_is_div  <= 1'b1;
                  r_cnt     <= c_div_iters;
                  r_state   <= ST_DIV;
                end
              end
              OP_MTHI: r_hi <= a;
              OP_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= (r_state == ST_DIV) ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - c_one;
            if (r_cnt == c_one) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          if (!flush) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_unit                                                  |
// | Purpose  : Scoreboard bench for muldiv_unit (radix 1 and radix 4 copies). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start4 = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;

  logic        busy, done, dbz, busy4, done4, dbz4;
  logic [31:0] hi, lo, hi4, lo4;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_RADIX_BITS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo));

  muldiv_unit #(.WIDTH(32), .MUL_RADIX_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completion against the oldest expected result
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (done) begin
        if (q0.size() == 0) chk("dut_unexpected_done", 64'(done), 64'd0);
        else begin
          e = q0.pop_front();
          chk("dut_hi", 64'(hi), 64'(e.hi));
          chk("dut_lo", 64'(lo), 64'(e.lo));
          chk("dut_dbz", 64'(dbz), 64'(e.dbz));
        end
      end else if (dbz) chk("dut_dbz_without_done", 64'(dbz), 64'd0);
      if (done4) begin
        if (q4.size() == 0) chk("dut4_unexpected_done", 64'(done4), 64'd0);
        else begin
          e = q4.pop_front();
          chk("dut4_hi", 64'(hi4), 64'(e.hi));
          chk("dut4_lo", 64'(lo4), 64'(e.lo));
          chk("dut4_dbz", 64'(dbz4), 64'(e.dbz));
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge (E0)
  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input bit push, input logic [31:0] eh,
                       input logic [31:0] el, input bit ed);
    exp_t e;
    op = o; a = aa; b = bb;
    if (sel) start4 = 1'b1; else start = 1'b1;
    if (push) begin
      e.hi = eh; e.lo = el; e.dbz = ed;
      if (sel) q4.push_back(e); else q0.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
  endtask

  // Counts negedges after E0 until done, plus how many of them saw busy
  task automatic wait_done(input bit sel, input int exp_lat, input string name);
    int lat = 0;
    int bc = 0;
    while (!(sel ? done4 : done) && lat < 200) begin
      if (sel ? busy4 : busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
    chk({name, "_busy_at_done"}, 64'(sel ? busy4 : busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    wait_done(0, 33, "multu_max");
    issue(0, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    wait_done(0, 33, "mult_neg");
    issue(1, OP_MULT, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    wait_done(1, 9, "mult_radix4");

    issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    wait_done(0, 33, "div_neg");
    issue(0, OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_done(0, 33, "divu");
    issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0);
    wait_done(0, 33, "div_ovf");

    issue(0, OP_MTHI, 32'h11, 32'd0, 0, 0, 0, 0);
    issue(0, OP_MTLO, 32'h22, 32'd0, 0, 0, 0, 0);
    chk("mthi_value", 64'(hi), 64'h11);
    chk("mtlo_value", 64'(lo), 64'h22);
    issue(0, OP_DIVU, 32'd7, 32'd0, 1, 32'h11, 32'h22, 1);
    wait_done(0, 0, "div_by_zero");

    // Flush mid-multiply, with an ignored start while busy
    issue(0, OP_MULT, 32'd6, 32'd7, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    issue(0, OP_MTHI, 32'hDEAD, 32'd0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    repeat (40) @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first
    issue(0, OP_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0);
    wait_done(0, 33, "b2b_first");
    issue(0, OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0);
    wait_done(0, 33, "b2b_second");

    // Asynchronous reset in the middle of a divide
    issue(0, OP_DIV, 32'd100, 32'd7, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(0, OP_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0);
    wait_done(0, 33, "post_rst_mul");

    @(negedge clk);
    chk("queue0_drained", 64'(q0.size()), 64'd0);
    chk("queue4_drained", 64'(q4.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
